// File: rtl/irq_controller.sv
// irq_controller: latches NSRC interrupt sources, masks and prioritises them,
// drives the CPU IRQ/IRQn/IRQAck handshake and blocks nesting until EOI.
// Memory-mapped at BASE_ADDR+0..+3: MASK, PENDING (W1C), EOI, STATUS.
// Build option: define IRQ_EDGE_EN for rising-edge sources (level otherwise).
module irq_controller #(
    parameter int unsigned NSRC      = 8,
    parameter logic [13:0] BASE_ADDR = 14'h3FF0,
    parameter logic [11:0] VEC_BASE  = 12'h010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [13:0]     busAddr,
    input  logic [31:0]     busWrData,
    input  logic            busWrEn,
    output logic [31:0]     busRdData,
    output logic            IRQ,
    output logic [11:0]     IRQn,
    input  logic            IRQAck
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] cand;
    logic            in_service;
    logic            in_service_nxt;
    logic            irq_nxt;
    logic [11:0]     irqn_nxt;
    logic [3:0]      active;
    logic [3:0]      active_nxt;
    logic [3:0]      sel;
    logic            found;
    logic            ack_clr;
    logic [13:0]     off;
    logic            in_range;
    logic            wr_mask;
    logic            wr_w1c;
    logic            wr_eoi;
    logic [31:0]     rd_nxt;
    logic            unused_wdata;

    // Register window decode; addresses below BASE_ADDR wrap to large offsets
    assign off      = busAddr - BASE_ADDR;
    assign in_range = (off < 14'd4);
    assign wr_mask  = busWrEn & in_range & (off == 14'd0);
    assign wr_w1c   = busWrEn & in_range & (off == 14'd1);
    assign wr_eoi   = busWrEn & in_range & (off == 14'd2);

    assign unused_wdata = ^busWrData[31:NSRC];

`ifdef IRQ_EDGE_EN
    logic [NSRC-1:0] src_q;

    // Previous source sample for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= src;
        end
    end

    assign set_vec = src & ~src_q;
`else
    assign set_vec = src;
`endif

    assign cand = pending & mask;

    // Lowest enabled pending index wins
    always_comb begin
        sel   = 4'd0;
        found = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel   = 4'(i);
                found = 1'b1;
            end
        end
    end

    // Handshake next-state and next request outputs
    always_comb begin
        state_nxt  = state;
        irq_nxt    = IRQ;
        irqn_nxt   = IRQn;
        active_nxt = active;
        ack_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_service && found) begin
                    state_nxt  = S_REQ;
                    irq_nxt    = 1'b1;
                    irqn_nxt   = VEC_BASE + 12'(sel);
                    active_nxt = sel;
                end
            end
            S_REQ: begin
                if (IRQAck) begin
                    state_nxt = S_REL;
                    irq_nxt   = 1'b0;
                    ack_clr   = 1'b1;
                end
            end
            S_REL: begin
                if (!IRQAck) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Clear sources (W1C and ack) and in-service update; ack sets, EOI clears
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr_vec[i] = (wr_w1c & busWrData[i]) | (ack_clr & (active == 4'(i)));
        end
        in_service_nxt = in_service;
        if (ack_clr) begin
            in_service_nxt = 1'b1;
        end else if (wr_eoi) begin
            in_service_nxt = 1'b0;
        end
    end

    // Read mux; EOI and out-of-window addresses read zero
    always_comb begin
        rd_nxt = 32'd0;
        if (in_range) begin
            case (off[1:0])
                2'd0:    rd_nxt = 32'(mask);
                2'd1:    rd_nxt = 32'(pending);
                2'd3:    rd_nxt = {24'd0, active, 2'b00, IRQ, in_service};
                default: rd_nxt = 32'd0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registers and outputs; a set event beats any clear of the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            mask       <= '0;
            pending    <= '0;
            in_service <= 1'b0;
            active     <= 4'd0;
            IRQ        <= 1'b0;
            IRQn       <= 12'd0;
            busRdData  <= 32'd0;
        end else begin
            if (wr_mask) begin
                mask <= busWrData[NSRC-1:0];
            end
            pending    <= (pending & ~clr_vec) | set_vec;
            in_service <= in_service_nxt;
            active     <= active_nxt;
            IRQ        <= irq_nxt;
            IRQn       <= irqn_nxt;
            busRdData  <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a random
// phase, every cycle compared against a behavioural model of the controller.
module tb_irq_controller;

    localparam logic [13:0] BASE = 14'h3FF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src = 8'd0;
    logic [13:0] busAddr = 14'd0;
    logic [31:0] busWrData = 32'd0;
    logic        busWrEn = 1'b0;
    logic [31:0] busRdData;
    logic        IRQ;
    logic [11:0] IRQn;
    logic        IRQAck = 1'b0;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [7:0]  m_mask, m_pend, m_prev;
    logic        m_insvc, m_irq, m_rel;
    logic [11:0] m_vec;
    logic [3:0]  m_act;
    logic [31:0] m_rd;

    irq_controller dut (
        .clk(clk), .rst(rst), .src(src), .busAddr(busAddr),
        .busWrData(busWrData), .busWrEn(busWrEn), .busRdData(busRdData),
        .IRQ(IRQ), .IRQn(IRQn), .IRQAck(IRQAck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the controller's rules, from the current inputs
    task automatic model_step();
        logic [7:0]  set, clr, cand;
        logic [13:0] off;
        logic        inr, wr, took;
        int          idx;
        if (rst) begin
            m_mask = 0; m_pend = 0; m_prev = 0; m_insvc = 0; m_irq = 0;
            m_rel = 0; m_vec = 0; m_act = 0; m_rd = 0;
            return;
        end
        off = busAddr - BASE;
        inr = (busAddr >= BASE) && (busAddr <= BASE + 14'd3);
        m_rd = 0;
        if (inr) begin
            if (off == 0) m_rd = {24'd0, m_mask};
            if (off == 1) m_rd = {24'd0, m_pend};
            if (off == 3) m_rd = {24'd0, m_act, 2'b00, m_irq, m_insvc};
        end
`ifdef IRQ_EDGE_EN
        set = src & ~m_prev;
`else
        set = src;
`endif
        m_prev = src;
        clr = 0;
        took = 0;
        cand = m_pend & m_mask;
        if (m_irq) begin
            if (IRQAck) begin
                m_irq = 0; clr[m_act] = 1'b1; took = 1; m_rel = 1;
            end
        end else if (m_rel) begin
            if (!IRQAck) m_rel = 0;
        end else if (!m_insvc && cand != 0) begin
            idx = 0;
            for (int i = 7; i >= 0; i--) if (cand[i]) idx = i;
            m_irq = 1;
            m_vec = 12'h010 + 12'(idx);
            m_act = 4'(idx);
        end
        wr = busWrEn && inr;
        if (wr && off == 1) clr = clr | busWrData[7:0];
        if (took) m_insvc = 1;
        else if (wr && off == 2) m_insvc = 0;
        if (wr && off == 0) m_mask = busWrData[7:0];
        m_pend = (m_pend & ~clr) | set;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_irq", 32'(IRQ), 32'(m_irq));
        check("model_irqn", 32'(IRQn), 32'(m_vec));
        check("model_rd", busRdData, m_rd);
    endtask

    task automatic wr(input logic [1:0] o, input logic [31:0] d);
        busAddr = BASE + 14'(o);
        busWrData = d;
        busWrEn = 1'b1;
        tick();
        busWrEn = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] o, input logic [31:0] exp);
        busAddr = BASE + 14'(o);
        tick();
        check(tag, busRdData, exp);
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!IRQ && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(IRQ), 32'd1);
    endtask

    task automatic ack_cycle();
        IRQAck = 1'b1;
        tick();
        IRQAck = 1'b0;
        tick();
    endtask

    initial begin
        int rises;
        logic prev_irq;

        // Reset
        rst = 1'b1;
        tick();
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_irqn", 32'(IRQn), 32'd0);
        check("rst_rd", busRdData, 32'd0);
        rst = 1'b0;

        // 1: basic request, two-cycle latency, ack handshake
        wr(2'd0, 32'h04);
        src = 8'h04;
        tick();
        src = 8'h00;
        tick();
        check("t1_irq", 32'(IRQ), 32'd1);
        check("t1_irqn", 32'(IRQn), 32'h012);
        IRQAck = 1'b1;
        tick();
        check("t1_irq_drop", 32'(IRQ), 32'd0);
        IRQAck = 1'b0;
        rd_check("t1_pending", 2'd1, 32'h00);
        rd_check("t1_status", 2'd3, 32'h21);
        wr(2'd2, 32'h0);

        // 2: priority, second source waits for EOI
        wr(2'd0, 32'hFF);
        src = 8'h22;
        tick();
        src = 8'h00;
        wait_irq("t2_first");
        check("t2_irqn_first", 32'(IRQn), 32'h011);
        ack_cycle();
        tick(); tick(); tick();
        check("t2_blocked", 32'(IRQ), 32'd0);
        rd_check("t2_pending", 2'd1, 32'h20);
        wr(2'd2, 32'h0);
        wait_irq("t2_second");
        check("t2_irqn_second", 32'(IRQn), 32'h015);
        ack_cycle();

        // 3: pending while in service, EOI releases it
        src = 8'h08;
        tick();
        src = 8'h00;
        tick(); tick();
        check("t3_blocked", 32'(IRQ), 32'd0);
        rd_check("t3_pending", 2'd1, 32'h08);
        wr(2'd2, 32'h0);
        tick();
        check("t3_irq", 32'(IRQ), 32'd1);
        check("t3_irqn", 32'(IRQn), 32'h013);
        ack_cycle();
        wr(2'd2, 32'h0);

        // 4: masked source, then unmask; set beats same-cycle W1C
        wr(2'd0, 32'h00);
        src = 8'h01;
        tick();
        src = 8'h00;
        tick(); tick();
        check("t4_masked", 32'(IRQ), 32'd0);
        rd_check("t4_pending", 2'd1, 32'h01);
        wr(2'd0, 32'h01);
        tick();
        check("t4_irq", 32'(IRQ), 32'd1);
        check("t4_irqn", 32'(IRQn), 32'h010);
        ack_cycle();
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h00);
        src = 8'h01;
        wr(2'd1, 32'h01);
        src = 8'h00;
        rd_check("t4_set_beats_w1c", 2'd1, 32'h01);
        wr(2'd1, 32'h01);
        rd_check("t4_w1c", 2'd1, 32'h00);

        // 5: request held through MASK/W1C writes, then reset mid-request
        wr(2'd0, 32'hFF);
        src = 8'h40;
        tick();
        src = 8'h00;
        wait_irq("t5");
        wr(2'd0, 32'h00);
        check("t5_hold_mask_irq", 32'(IRQ), 32'd1);
        check("t5_hold_mask_irqn", 32'(IRQn), 32'h016);
        wr(2'd1, 32'hFF);
        tick();
        check("t5_hold_w1c_irq", 32'(IRQ), 32'd1);
        check("t5_hold_w1c_irqn", 32'(IRQn), 32'h016);
        rst = 1'b1;
        tick();
        check("t5_rst_irq", 32'(IRQ), 32'd0);
        check("t5_rst_irqn", 32'(IRQn), 32'd0);
        rst = 1'b0;
        rd_check("t5_mask0", 2'd0, 32'd0);
        rd_check("t5_pend0", 2'd1, 32'd0);
        rd_check("t5_status0", 2'd3, 32'd0);

        // 6: src[4] held high five cycles; edge gives one request, level re-pends
        wr(2'd0, 32'h10);
        rises = 0;
        prev_irq = IRQ;
        for (int t = 0; t < 12; t++) begin
            src = (t < 5) ? 8'h10 : 8'h00;
            busAddr = BASE + 14'd2;
            busWrEn = (t == 5);
            IRQAck = IRQ;
            tick();
            if (IRQ && !prev_irq) rises++;
            prev_irq = IRQ;
        end
        busWrEn = 1'b0;
        IRQAck = 1'b0;
`ifdef IRQ_EDGE_EN
        check("t6_requests", 32'(rises), 32'd1);
`else
        check("t6_requests", 32'(rises), 32'd2);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            src = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            busAddr = 14'h3FEE + 14'($urandom_range(0, 7));
            busWrData = $urandom;
            busWrEn = ($urandom_range(0, 3) == 0);
            IRQAck = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 1'b0;
        busWrEn = 1'b0;
        IRQAck = 1'b0;
        src = 8'h00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
